// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and helpers for the serial_to_parallel_rx receiver.
//   s2p_state_t    receive FSM state encoding
//   s2p_cnt_width  width of the bit counter for a given word width
// Optional feature macro used by the importing files: PARITY_CHECK_EN.
package s2p_pkg;

  typedef enum logic [1:0] {
    S2P_IDLE   = 2'd0,
    S2P_SHIFT  = 2'd1,
    S2P_PARITY = 2'd2
  } s2p_state_t;

  // The counter has to reach DATA_W, which marks the parity slot when parity is enabled.
  function automatic int s2p_cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/s2p_if.sv
// s2p_if: serial-in / parallel-out bus of the serial_to_parallel_rx receiver.
//   serial_i, valid_i   serial bit stream, LSB first, valid-qualified
//   ready_i             downstream consumer accepts parallel_o
//   parallel_o, valid_o received word and its valid flag
//   busy_o              a frame is partially received
//   overrun_o           one-cycle pulse: a completed word was dropped
//   parity_err_o        parity result that belongs to parallel_o
// Modport master is the stream source / word consumer side; slave is the receiver.
// Optional feature macro affecting the receiver behind this bus: PARITY_CHECK_EN.
interface s2p_if #(
  parameter int DATA_W = 4
);

  logic              serial_i;
  logic              valid_i;
  logic              ready_i;
  logic [DATA_W-1:0] parallel_o;
  logic              valid_o;
  logic              busy_o;
  logic              overrun_o;
  logic              parity_err_o;

  modport master (
    output serial_i, valid_i, ready_i,
    input  parallel_o, valid_o, busy_o, overrun_o, parity_err_o
  );

  modport slave (
    input  serial_i, valid_i, ready_i,
    output parallel_o, valid_o, busy_o, overrun_o, parity_err_o
  );

endinterface

// File: rtl/s2p_out_buf.sv
// s2p_out_buf: one-entry valid/ready holding register for received words.
//   clk, reset     clock and asynchronous active-high reset
//   load_i         a word completes this cycle
//   word_i         completed word
//   parity_err_i   parity result of the completed word
//   ready_i        consumer accepts the held word when valid_o is high
//   valid_o        holding register contains an unconsumed word
//   parallel_o     held word, stable while valid_o && !ready_i
//   parity_err_o   parity result stored alongside parallel_o
//   free_o         a load this cycle would be accepted
// Optional feature macro of the enclosing receiver: PARITY_CHECK_EN (only changes what
// drives parity_err_i).
module s2p_out_buf #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              parity_err_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] parallel_o,
  output logic              parity_err_o,
  output logic              free_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              perr_q, perr_d;

  // Free when empty, or when the held word is being handed off this very cycle,
  // which lets a new word replace it without a bubble in valid_o.
  assign free_o = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    perr_d  = perr_q;
    if (load_i && free_o) begin
      valid_d = 1'b1;
      data_d  = word_i;
      perr_d  = parity_err_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
    end
  end

  assign valid_o      = valid_q;
  assign parallel_o   = data_q;
  assign parity_err_o = perr_q;

endmodule

// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: receive-side deserializer.
// Collects a valid-qualified LSB-first bit stream into DATA_W-bit words and presents
// them through a one-entry valid/ready holding register. A word that completes while
// the previous one is still waiting is dropped and reported with a one-cycle overrun pulse.
//   clk        clock, rising edge
//   reset      asynchronous, active-high
//   bus        s2p_if slave modport (serial_i, valid_i, ready_i in;
//              parallel_o, valid_o, busy_o, overrun_o, parity_err_o out)
// Optional feature macro: PARITY_CHECK_EN. When defined each frame carries one extra
// even-parity bit after the data bits and parity_err_o reports its check; when
// undefined frames are DATA_W bits and parity_err_o is constant 0.
module serial_to_parallel_rx
  import s2p_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic  clk,
  input  logic  reset,
  s2p_if.slave  bus
);

  localparam int CNT_W = s2p_cnt_width(DATA_W);

  s2p_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              overrun_q, overrun_d;

  logic              complete;
  logic [DATA_W-1:0] word_done;
  logic              parity_bad;
  logic              buf_free;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;
  logic              buf_perr;

  // Receive FSM: bits land at position cnt; the frame completes on the last data bit
  // (no parity) or on the parity bit. valid_i low simply holds everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    complete   = 1'b0;
    word_done  = shift_q;
    parity_bad = 1'b0;
    case (state_q)
      S2P_IDLE, S2P_SHIFT: begin
        if (bus.valid_i) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (cnt_q == CNT_W'(i)) shift_d[i] = bus.serial_i;
          end
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef PARITY_CHECK_EN
            cnt_d   = CNT_W'(DATA_W);
            state_d = S2P_PARITY;
`else
            // The final bit is merged into the word before it is handed off.
            complete  = 1'b1;
            word_done = shift_d;
            shift_d   = '0;
            cnt_d     = '0;
            state_d   = S2P_IDLE;
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S2P_SHIFT;
          end
        end
      end
      S2P_PARITY: begin
`ifdef PARITY_CHECK_EN
        if (bus.valid_i) begin
          // Even parity: all data bits plus the parity bit must XOR to zero.
          complete   = 1'b1;
          word_done  = shift_q;
          parity_bad = ^{bus.serial_i, shift_q};
          shift_d    = '0;
          cnt_d      = '0;
          state_d    = S2P_IDLE;
        end
`else
        cnt_d   = '0;
        shift_d = '0;
        state_d = S2P_IDLE;
`endif
      end
      default: begin
        cnt_d   = '0;
        shift_d = '0;
        state_d = S2P_IDLE;
      end
    endcase
  end

  // A completed frame that finds the holding register occupied is dropped; the FSM
  // has already restarted at IDLE above, so only the pulse needs generating.
  always_comb begin
    overrun_d = complete && !buf_free;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S2P_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      overrun_q <= overrun_d;
    end
  end

  s2p_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk          (clk),
    .reset        (reset),
    .load_i       (complete),
    .word_i       (word_done),
    .parity_err_i (parity_bad),
    .ready_i      (bus.ready_i),
    .valid_o      (buf_valid),
    .parallel_o   (buf_data),
    .parity_err_o (buf_perr),
    .free_o       (buf_free)
  );

  assign bus.valid_o      = buf_valid;
  assign bus.parallel_o   = buf_data;
  assign bus.parity_err_o = buf_perr;
  assign bus.busy_o       = (cnt_q != '0);
  assign bus.overrun_o    = overrun_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb_serial_to_parallel_rx: directed self-checking bench for serial_to_parallel_rx
// with DATA_W=4. Inputs change and outputs are sampled on the falling clock edge.
// Optional feature macro: PARITY_CHECK_EN (frames gain an even-parity bit and the
// parity scenario checks parity_err_o both ways).
module tb_serial_to_parallel_rx;

  localparam int DATA_W = 4;
`ifdef PARITY_CHECK_EN
  localparam int FRAME_N = DATA_W + 1;
`else
  localparam int FRAME_N = DATA_W;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  s2p_if #(.DATA_W(DATA_W)) bus ();

  serial_to_parallel_rx #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Data bits in [3:0], even-parity bit in [4] (only sent with parity enabled).
  function automatic logic [4:0] frame_of(input logic [3:0] w);
    return {^w, w};
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.valid_i  = 1'b1;
    bus.serial_i = b;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.valid_i  = 1'b0;
    bus.serial_i = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] w);
    logic [4:0] f;
    f = frame_of(w);
    for (int i = 0; i < FRAME_N; i++) send_bit(f[i]);
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.valid_i  = 1'b0;
    bus.serial_i = 1'b0;
    bus.ready_i  = 1'b0;
    #2;
    total++; if (bus.parallel_o !== 4'h0) begin bad++; $display("[TB] FAIL reset_parallel: got %h want 0", bus.parallel_o); end
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", bus.valid_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy_o); end
    total++; if (bus.overrun_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: got %b want 0", bus.overrun_o); end
    total++; if (bus.parity_err_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_perr: got %b want 0", bus.parity_err_o); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    bus.ready_i = 1'b1;
    send_frame(4'hD);
    idle_cycle();
    total++; if (bus.parallel_o !== 4'b1101) begin bad++; $display("[TB] FAIL basic_word: got %h want d", bus.parallel_o); end
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid: got %b want 1", bus.valid_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy: got %b want 0", bus.busy_o); end
    total++; if (bus.parity_err_o !== 1'b0) begin bad++; $display("[TB] FAIL basic_perr: got %b want 0", bus.parity_err_o); end
    idle_cycle();
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("[TB] FAIL basic_valid_drop: got %b want 0", bus.valid_o); end
  endtask

  task automatic test_gaps();
    logic [4:0] f;
    f = frame_of(4'hD);
    bus.ready_i = 1'b1;
    for (int i = 0; i < FRAME_N; i++) begin
      send_bit(f[i]);
      if (i < FRAME_N - 1) begin
        for (int g = 0; g < 3; g++) begin
          idle_cycle();
          total++; if (bus.busy_o !== 1'b1) begin bad++; $display("[TB] FAIL gap_busy bit%0d: got %b want 1", i, bus.busy_o); end
          total++; if (bus.valid_o !== 1'b0) begin bad++; $display("[TB] FAIL gap_valid bit%0d: got %b want 0", i, bus.valid_o); end
        end
      end
    end
    idle_cycle();
    total++; if (bus.parallel_o !== 4'hD) begin bad++; $display("[TB] FAIL gap_word: got %h want d", bus.parallel_o); end
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("[TB] FAIL gap_valid_end: got %b want 1", bus.valid_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("[TB] FAIL gap_busy_end: got %b want 0", bus.busy_o); end
    idle_cycle();
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("[TB] FAIL gap_valid_drop: got %b want 0", bus.valid_o); end
  endtask

  task automatic test_backpressure();
    bus.ready_i = 1'b0;
    send_frame(4'h5);
    idle_cycle();
    total++; if (bus.parallel_o !== 4'h5) begin bad++; $display("[TB] FAIL bp_first: got %h want 5", bus.parallel_o); end
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid1: got %b want 1", bus.valid_o); end
    total++; if (bus.overrun_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_overrun: got %b want 0", bus.overrun_o); end
    send_frame(4'hA);
    idle_cycle();
    total++; if (bus.overrun_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_overrun: got %b want 1", bus.overrun_o); end
    total++; if (bus.parallel_o !== 4'h5) begin bad++; $display("[TB] FAIL bp_held: got %h want 5", bus.parallel_o); end
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid2: got %b want 1", bus.valid_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_busy: got %b want 0", bus.busy_o); end
    idle_cycle();
    total++; if (bus.overrun_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_overrun_pulse: got %b want 0", bus.overrun_o); end
    total++; if (bus.parallel_o !== 4'h5) begin bad++; $display("[TB] FAIL bp_still_held: got %h want 5", bus.parallel_o); end
    bus.ready_i = 1'b1;
    idle_cycle();
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain: got %b want 0", bus.valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] f;
    bus.ready_i = 1'b0;
    send_frame(4'h9);
    idle_cycle();
    total++; if (bus.parallel_o !== 4'h9) begin bad++; $display("[TB] FAIL b2b_first: got %h want 9", bus.parallel_o); end
    f = frame_of(4'h3);
    for (int i = 0; i < FRAME_N - 1; i++) send_bit(f[i]);
    send_bit(f[FRAME_N-1]);
    bus.ready_i = 1'b1;
    idle_cycle();
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_valid: got %b want 1", bus.valid_o); end
    total++; if (bus.parallel_o !== 4'h3) begin bad++; $display("[TB] FAIL b2b_second: got %h want 3", bus.parallel_o); end
    total++; if (bus.overrun_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_overrun: got %b want 0", bus.overrun_o); end
    idle_cycle();
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain: got %b want 0", bus.valid_o); end
  endtask

  task automatic test_reset_midword();
    bus.ready_i = 1'b0;
    send_frame(4'h6);
    send_bit(1'b0);
    send_bit(1'b1);
    idle_cycle();
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy: got %b want 1", bus.busy_o); end
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("[TB] FAIL mid_valid: got %b want 1", bus.valid_o); end
    reset = 1'b1;
    #1;
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_valid: got %b want 0", bus.valid_o); end
    total++; if (bus.parallel_o !== 4'h0) begin bad++; $display("[TB] FAIL mid_rst_parallel: got %h want 0", bus.parallel_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_busy: got %b want 0", bus.busy_o); end
    total++; if (bus.overrun_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_overrun: got %b want 0", bus.overrun_o); end
    @(negedge clk);
    reset       = 1'b0;
    bus.ready_i = 1'b1;
    send_frame(4'hC);
    idle_cycle();
    total++; if (bus.parallel_o !== 4'hC) begin bad++; $display("[TB] FAIL mid_next_word: got %h want c", bus.parallel_o); end
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("[TB] FAIL mid_next_valid: got %b want 1", bus.valid_o); end
    total++; if (bus.overrun_o !== 1'b0) begin bad++; $display("[TB] FAIL mid_next_overrun: got %b want 0", bus.overrun_o); end
    idle_cycle();
  endtask

  task automatic test_parity();
    bus.ready_i = 1'b1;
    send_frame(4'h7);
    idle_cycle();
    total++; if (bus.parity_err_o !== 1'b0) begin bad++; $display("[TB] FAIL par_good: got %b want 0", bus.parity_err_o); end
    total++; if (bus.parallel_o !== 4'h7) begin bad++; $display("[TB] FAIL par_good_word: got %h want 7", bus.parallel_o); end
`ifdef PARITY_CHECK_EN
    begin
      logic [4:0] badf;
      badf = {1'b0, 4'h7};
      for (int i = 0; i < FRAME_N; i++) send_bit(badf[i]);
    end
    idle_cycle();
    total++; if (bus.parity_err_o !== 1'b1) begin bad++; $display("[TB] FAIL par_bad: got %b want 1", bus.parity_err_o); end
    total++; if (bus.parallel_o !== 4'h7) begin bad++; $display("[TB] FAIL par_bad_word: got %h want 7", bus.parallel_o); end
    total++; if (bus.valid_o !== 1'b1) begin bad++; $display("[TB] FAIL par_bad_valid: got %b want 1", bus.valid_o); end
`else
    send_frame(4'h8);
    idle_cycle();
    total++; if (bus.parity_err_o !== 1'b0) begin bad++; $display("[TB] FAIL par_tied: got %b want 0", bus.parity_err_o); end
    total++; if (bus.parallel_o !== 4'h8) begin bad++; $display("[TB] FAIL par_word8: got %h want 8", bus.parallel_o); end
`endif
    idle_cycle();
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("[TB] FAIL par_drain: got %b want 0", bus.valid_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_back_to_back();
    test_reset_midword();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
